// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor.
// Operands are captured on acceptance, then resolved one bit per cycle, LSB first,
// through a single full-adder cell and a carry flip-flop.
// The result registers (sum, cout, ovf) change only when the final bit resolves.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. The producer holds valid and payload steady until that
// edge. The consumer may raise ready at any time. in_ready is high only in IDLE.
// out_valid is high only in DONE. A result is never consumed in the same cycle
// that new operands are accepted.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // holds the effective operand (inverted for subtract)
  logic [WIDTH-1:0] sh_q, sh_d;   // internal result shifter, filled from the MSB end
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic accept;
  logic last_bit;
  logic fa_s;
  logic fa_co;

  assign accept   = in_valid && (state_q == IDLE);
  assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

  // Single full-adder cell working on the current LSBs of the operand shifters
  assign fa_s  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_co = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    dbg_state_o = state_q;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath next values: capture on accept, shift one bit per RUN cycle, publish on last bit
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? ~cin : cin;
      cnt_d   = '0;
      sh_d    = '0;
    end else if (state_q == RUN) begin
      a_d     = {1'b0, a_q[WIDTH-1:1]};
      b_d     = {1'b0, b_q[WIDTH-1:1]};
      sh_d    = {fa_s, sh_q[WIDTH-1:1]};
      carry_d = fa_co;
      cnt_d   = cnt_q + CW'(1);
      if (last_bit) begin
        sum_d  = {fa_s, sh_q[WIDTH-1:1]};
        cout_d = fa_co;
        // carry_q is the carry into the MSB at this point
        ovf_d  = carry_q ^ fa_co;
        cnt_d  = '0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
